// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache, one 32-bit word per line.
//               Hits return a word one cycle after the request; a miss issues
//               a single word read to the memory unit, holds it until
//               in_mem_ok, then fills the line and forwards the word.
// Ports       : clk, rst (async active-low), ena (global freeze when low)
//               in_clear                    : misbranch flush
//               in_fetcher_ena/_addr        : fetch request
//               out_fetcher_ok/_inst        : one-cycle result pulse
//               out_mem_ena/_addr           : word read request to memory
//               in_mem_ok/_data             : memory read completion
// Revision    : 1.0 - initial release
// ============================================================================
module icache #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        in_clear,
    input  logic        in_fetcher_ena,
    input  logic [31:0] in_fetcher_addr,
    output logic        out_fetcher_ok,
    output logic [31:0] out_fetcher_inst,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MISS = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              fetcher_ok_q, fetcher_ok_d;
    logic [31:0]       fetcher_inst_q, fetcher_inst_d;
    logic              mem_ena_q, mem_ena_d;
    logic [31:0]       mem_addr_q, mem_addr_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]      fill_tag;
    logic                  hit;
    logic                  fill_we;

    // Byte-offset bits of the request never select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^in_fetcher_addr[1:0];

    assign req_idx  = in_fetcher_addr[INDEX_BITS+1:2];
    assign req_tag  = in_fetcher_addr[31:INDEX_BITS+2];
    // The outstanding read address doubles as the latched miss address.
    assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
    assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    always_comb begin
        state_d        = state_q;
        fetcher_ok_d   = fetcher_ok_q;
        fetcher_inst_d = fetcher_inst_q;
        mem_ena_d      = mem_ena_q;
        mem_addr_d     = mem_addr_q;
        fill_we        = 1'b0;

        if (ena) begin
            fetcher_ok_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    // in_mem_ok is deliberately ignored here.
                    if (in_clear) begin
                        mem_ena_d = 1'b0;
                    end else if (in_fetcher_ena) begin
                        if (hit) begin
                            fetcher_ok_d   = 1'b1;
                            fetcher_inst_d = data_q[req_idx];
                        end else begin
                            mem_ena_d  = 1'b1;
                            mem_addr_d = {in_fetcher_addr[31:2], 2'b00};
                            state_d    = S_MISS;
                        end
                    end
                end
                S_MISS: begin
                    if (in_mem_ok) begin
                        // A flush still keeps the returned word; only the
                        // response to the fetcher is dropped.
                        fill_we   = 1'b1;
                        mem_ena_d = 1'b0;
                        state_d   = S_IDLE;
                        if (!in_clear) begin
                            fetcher_ok_d   = 1'b1;
                            fetcher_inst_d = in_mem_data;
                        end
                    end else if (in_clear) begin
                        mem_ena_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    mem_ena_d = 1'b0;
                    state_d   = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            fetcher_ok_q   <= 1'b0;
            fetcher_inst_q <= 32'h0;
            mem_ena_q      <= 1'b0;
            mem_addr_q     <= 32'h0;
            valid_q        <= '0;
        end else begin
            state_q        <= state_d;
            fetcher_ok_q   <= fetcher_ok_d;
            fetcher_inst_q <= fetcher_inst_d;
            mem_ena_q      <= mem_ena_d;
            mem_addr_q     <= mem_addr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= in_mem_data;
        end
    end

    assign out_fetcher_ok   = fetcher_ok_q;
    assign out_fetcher_inst = fetcher_inst_q;
    assign out_mem_ena      = mem_ena_q;
    assign out_mem_addr     = mem_addr_q;

endmodule
`default_nettype wire
